axil_master: RTL and testbench

AXIL_MASTER -- requirements
Module: axil_master

---
 rtl/axil_pkg.sv | 19 +
 rtl/axil_master_if.sv | 37 +++
 rtl/axil_master.sv | 161 ++++++++++++++++
 tb/tb_axil_master.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite master: FSM states, response codes, default widths.
package axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    WR      = 2'd2,
    WR_RESP = 2'd3
  } axil_state_t;

endpackage

// File: rtl/axil_master_if.sv
// AXI4-Lite bus bundle (AR, R, AW, W, B channels) with master and slave views.
interface axil_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AXI_ARADDR;
  logic                AXI_ARVALID;
  logic                AXI_ARREADY;
  logic [DATA_W-1:0]   AXI_RDATA;
  logic [1:0]          AXI_RRESP;
  logic                AXI_RVALID;
  logic                AXI_RREADY;
  logic [ADDR_W-1:0]   AXI_AWADDR;
  logic                AXI_AWVALID;
  logic                AXI_AWREADY;
  logic [DATA_W-1:0]   AXI_WDATA;
  logic [DATA_W/8-1:0] AXI_WSTRB;
  logic                AXI_WVALID;
  logic                AXI_WREADY;
  logic [1:0]          AXI_BRESP;
  logic                AXI_BVALID;
  logic                AXI_BREADY;

  modport master (
    output AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
    output AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WSTRB, AXI_WVALID, AXI_BREADY,
    input  AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID,
    input  AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID
  );

  modport slave (
    input  AXI_ARADDR, AXI_ARVALID, AXI_RREADY,
    input  AXI_AWADDR, AXI_AWVALID, AXI_WDATA, AXI_WSTRB, AXI_WVALID, AXI_BREADY,
    output AXI_ARREADY, AXI_RDATA, AXI_RRESP, AXI_RVALID,
    output AXI_AWREADY, AXI_WREADY, AXI_BRESP, AXI_BVALID
  );
endinterface

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master bridging a CPU request/response port onto the bus.
// Optional macro AXIL_MASTER_WSTRB_EN adds req_wstrb; otherwise AXI_WSTRB is all-ones during WVALID.
module axil_master
  import axil_pkg::*;
#(
  parameter int ADDR_W = AXIL_ADDR_W,
  parameter int DATA_W = AXIL_DATA_W
) (
  input  logic              AXI_ACLK,
  input  logic              AXI_ARESET,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef AXIL_MASTER_WSTRB_EN
  input  logic [DATA_W/8-1:0] req_wstrb,
`endif
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  axil_master_if.master     m_axi
);

  localparam int STRB_W = DATA_W / 8;

  axil_state_t         r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_arvalid;
  logic                r_rready;
  logic [ADDR_W-1:0]   r_awaddr;
  logic                r_awvalid;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_wvalid;
  logic                r_bready;

  logic w_accept;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_aw_fin;
  logic w_w_fin;
  logic w_unused;

  assign w_accept = req_valid && r_req_ready && (r_state == IDLE);
  assign w_ar_hs  = r_arvalid && m_axi.AXI_ARREADY;
  assign w_r_hs   = r_rready  && m_axi.AXI_RVALID;
  assign w_aw_hs  = r_awvalid && m_axi.AXI_AWREADY;
  assign w_w_hs   = r_wvalid  && m_axi.AXI_WREADY;
  assign w_b_hs   = r_bready  && m_axi.AXI_BVALID;
  // A channel is finished once its VALID has dropped or its handshake happens this cycle.
  assign w_aw_fin = !r_awvalid || m_axi.AXI_AWREADY;
  assign w_w_fin  = !r_wvalid  || m_axi.AXI_WREADY;
  assign w_unused = &{1'b0, m_axi.AXI_RRESP[0], m_axi.AXI_BRESP[0]};

  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (req_we) begin
              r_state   <= WR;
              r_awaddr  <= req_addr;
              r_awvalid <= 1'b1;
              r_wdata   <= req_wdata;
`ifdef AXIL_MASTER_WSTRB_EN
              r_wstrb   <= req_wstrb;
`else
              r_wstrb   <= '1;
`endif
              r_wvalid  <= 1'b1;
              r_bready  <= 1'b1;
            end else begin
              r_state   <= RD;
              r_araddr  <= req_addr;
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
            end
          end
        end
        RD: begin
          if (w_ar_hs) r_arvalid <= 1'b0;
          if (w_r_hs) begin
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= m_axi.AXI_RDATA;
            r_rsp_err   <= m_axi.AXI_RRESP[1];
            r_state     <= IDLE;
          end
        end
        WR, WR_RESP: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
`ifndef AXIL_MASTER_WSTRB_EN
            r_wstrb  <= '0;
`endif
          end
          // BREADY is already high in WR, so a response is taken wherever it arrives.
          if (w_b_hs) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
`ifndef AXIL_MASTER_WSTRB_EN
            r_wstrb     <= '0;
`endif
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= m_axi.AXI_BRESP[1];
            r_state     <= IDLE;
          end else if (r_state == WR && w_aw_fin && w_w_fin) begin
            r_state <= WR_RESP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready         = r_req_ready;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_rdata         = r_rsp_rdata;
  assign rsp_err           = r_rsp_err;
  assign m_axi.AXI_ARADDR  = r_araddr;
  assign m_axi.AXI_ARVALID = r_arvalid;
  assign m_axi.AXI_RREADY  = r_rready;
  assign m_axi.AXI_AWADDR  = r_awaddr;
  assign m_axi.AXI_AWVALID = r_awvalid;
  assign m_axi.AXI_WDATA   = r_wdata;
  assign m_axi.AXI_WSTRB   = r_wstrb;
  assign m_axi.AXI_WVALID  = r_wvalid;
  assign m_axi.AXI_BREADY  = r_bready;

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: reads, writes, error responses, reset abort, back-to-back requests.
module tb_axil_master;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = 4'b0011;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

`ifdef AXIL_MASTER_WSTRB_EN
  localparam logic [3:0] EXP_STRB = 4'b0011;
`else
  localparam logic [3:0] EXP_STRB = 4'b1111;
`endif

  axil_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axil_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .AXI_ACLK   (clk),
    .AXI_ARESET (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef AXIL_MASTER_WSTRB_EN
    .req_wstrb  (req_wstrb),
`endif
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .m_axi      (axi.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    axi.AXI_ARREADY = 1'b0;
    axi.AXI_RDATA   = '0;
    axi.AXI_RRESP   = RESP_OKAY;
    axi.AXI_RVALID  = 1'b0;
    axi.AXI_AWREADY = 1'b0;
    axi.AXI_WREADY  = 1'b0;
    axi.AXI_BRESP   = RESP_OKAY;
    axi.AXI_BVALID  = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_arvalid", axi.AXI_ARVALID, 0);
    chk("rst_awvalid", axi.AXI_AWVALID, 0);
    chk("rst_wvalid", axi.AXI_WVALID, 0);
    chk("rst_wstrb", axi.AXI_WSTRB, 0);
    chk("rst_bready", axi.AXI_BREADY, 0);
    rst = 1'b0;
    tick();
    chk("idle_req_ready", req_ready, 1);
    chk("idle_rready", axi.AXI_RREADY, 0);

    // Stray RVALID/BVALID in IDLE are ignored
    axi.AXI_RVALID = 1'b1; axi.AXI_BVALID = 1'b1; axi.AXI_RDATA = 32'h55;
    tick();
    axi.AXI_RVALID = 1'b0; axi.AXI_BVALID = 1'b0;
    chk("stray_rsp_valid", rsp_valid, 0);

    // Read 0x10 -> 0xDEADBEEF OKAY
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    tick();
    req_valid = 1'b0;
    chk("rd_arvalid", axi.AXI_ARVALID, 1);
    chk("rd_araddr", axi.AXI_ARADDR, 32'h10);
    chk("rd_rready", axi.AXI_RREADY, 1);
    chk("rd_req_ready", req_ready, 0);
    tick();
    chk("rd_ar_hold", axi.AXI_ARVALID, 1);
    chk("rd_addr_hold", axi.AXI_ARADDR, 32'h10);
    axi.AXI_ARREADY = 1'b1;
    tick();
    axi.AXI_ARREADY = 1'b0;
    chk("rd_ar_drop", axi.AXI_ARVALID, 0);
    chk("rd_rready_hold", axi.AXI_RREADY, 1);
    axi.AXI_RVALID = 1'b1; axi.AXI_RDATA = 32'hDEADBEEF; axi.AXI_RRESP = RESP_OKAY;
    tick();
    axi.AXI_RVALID = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_rready_drop", axi.AXI_RREADY, 0);
    tick();
    chk("rd_rsp_pulse", rsp_valid, 0);
    chk("rd_rdata_zero", rsp_rdata, 0);
    chk("rd_back_ready", req_ready, 1);

    // Write 0x20=0x12345678, AW ready 3 cycles before W
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_wstrb = 4'b0011;
    tick();
    req_valid = 1'b0;
    chk("wr_awvalid", axi.AXI_AWVALID, 1);
    chk("wr_wvalid", axi.AXI_WVALID, 1);
    chk("wr_awaddr", axi.AXI_AWADDR, 32'h20);
    chk("wr_wdata", axi.AXI_WDATA, 32'h12345678);
    chk("wr_wstrb", axi.AXI_WSTRB, EXP_STRB);
    chk("wr_bready", axi.AXI_BREADY, 1);
    axi.AXI_AWREADY = 1'b1;
    tick();
    axi.AXI_AWREADY = 1'b0;
    chk("wr_aw_drop", axi.AXI_AWVALID, 0);
    chk("wr_w_hold", axi.AXI_WVALID, 1);
    tick();
    tick();
    chk("wr_w_hold3", axi.AXI_WVALID, 1);
    chk("wr_wdata_hold", axi.AXI_WDATA, 32'h12345678);
    chk("wr_no_rsp", rsp_valid, 0);
    axi.AXI_WREADY = 1'b1;
    tick();
    axi.AXI_WREADY = 1'b0;
    chk("wr_w_drop", axi.AXI_WVALID, 0);
    chk("wr_bready_hold", axi.AXI_BREADY, 1);
    axi.AXI_BVALID = 1'b1; axi.AXI_BRESP = RESP_OKAY;
    tick();
    axi.AXI_BVALID = 1'b0;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("wr_bready_drop", axi.AXI_BREADY, 0);
    tick();
    chk("wr_rsp_pulse", rsp_valid, 0);

    // Read with SLVERR
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h44;
    tick();
    req_valid = 1'b0;
    axi.AXI_ARREADY = 1'b1;
    tick();
    axi.AXI_ARREADY = 1'b0;
    axi.AXI_RVALID = 1'b1; axi.AXI_RDATA = 32'hA5A5A5A5; axi.AXI_RRESP = RESP_SLVERR;
    tick();
    axi.AXI_RVALID = 1'b0; axi.AXI_RRESP = RESP_OKAY;
    chk("rderr_valid", rsp_valid, 1);
    chk("rderr_err", rsp_err, 1);
    chk("rderr_rdata", rsp_rdata, 32'hA5A5A5A5);
    tick();
    chk("rderr_err_clr", rsp_err, 0);

    // Write with DECERR, AW and W handshake together
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h48; req_wdata = 32'h0BADF00D;
    tick();
    req_valid = 1'b0;
    axi.AXI_AWREADY = 1'b1; axi.AXI_WREADY = 1'b1;
    tick();
    axi.AXI_AWREADY = 1'b0; axi.AXI_WREADY = 1'b0;
    chk("wrerr_aw_drop", axi.AXI_AWVALID, 0);
    chk("wrerr_w_drop", axi.AXI_WVALID, 0);
    axi.AXI_BVALID = 1'b1; axi.AXI_BRESP = RESP_DECERR;
    tick();
    axi.AXI_BVALID = 1'b0; axi.AXI_BRESP = RESP_OKAY;
    chk("wrerr_valid", rsp_valid, 1);
    chk("wrerr_err", rsp_err, 1);
    chk("wrerr_rdata", rsp_rdata, 0);
    tick();

    // Reset while ARVALID waits for ARREADY
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h80;
    tick();
    req_valid = 1'b0;
    chk("abort_arvalid", axi.AXI_ARVALID, 1);
    rst = 1'b1;
    #1;
    chk("abort_arvalid_now", axi.AXI_ARVALID, 0);
    chk("abort_araddr_now", axi.AXI_ARADDR, 0);
    chk("abort_rready_now", axi.AXI_RREADY, 0);
    chk("abort_req_ready", req_ready, 0);
    axi.AXI_ARREADY = 1'b1; axi.AXI_RVALID = 1'b1;
    tick();
    axi.AXI_ARREADY = 1'b0; axi.AXI_RVALID = 1'b0;
    chk("abort_no_rsp", rsp_valid, 0);
    rst = 1'b0;
    tick();
    chk("abort_ready_after", req_ready, 1);
    chk("abort_no_rsp2", rsp_valid, 0);
    chk("abort_arvalid_idle", axi.AXI_ARVALID, 0);

    // req_valid held across two reads
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30;
    tick();
    chk("b2b_first_arvalid", axi.AXI_ARVALID, 1);
    chk("b2b_ready_low", req_ready, 0);
    req_addr = 32'h34;
    axi.AXI_ARREADY = 1'b1;
    tick();
    axi.AXI_ARREADY = 1'b0;
    axi.AXI_RVALID = 1'b1; axi.AXI_RDATA = 32'h1111;
    tick();
    axi.AXI_RVALID = 1'b0;
    chk("b2b_rsp1", rsp_valid, 1);
    chk("b2b_rsp1_data", rsp_rdata, 32'h1111);
    chk("b2b_ready_during_rsp", req_ready, 0);
    tick();
    chk("b2b_ready_after_rsp", req_ready, 1);
    chk("b2b_not_yet", axi.AXI_ARVALID, 0);
    tick();
    req_valid = 1'b0;
    chk("b2b_second_arvalid", axi.AXI_ARVALID, 1);
    chk("b2b_second_addr", axi.AXI_ARADDR, 32'h34);
    chk("b2b_second_ready", req_ready, 0);
    axi.AXI_ARREADY = 1'b1;
    tick();
    axi.AXI_ARREADY = 1'b0;
    axi.AXI_RVALID = 1'b1; axi.AXI_RDATA = 32'h2222;
    tick();
    axi.AXI_RVALID = 1'b0;
    chk("b2b_rsp2", rsp_valid, 1);
    chk("b2b_rsp2_data", rsp_rdata, 32'h2222);
    tick();
    chk("b2b_idle", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
